// File: rtl/bcd_down_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_down_timer                                               |
// | Description : Loadable multi-digit BCD countdown timer with IDLE/RUN/      |
// |               PAUSE/DONE control; flags zero and pulses done at expiry.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bcd_down_timer #(
   parameter int DIGITS = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tick,
   input  logic                load,
   input  logic [4*DIGITS-1:0] load_val,
   input  logic                start,
   input  logic                pause,
   output logic [4*DIGITS-1:0] q,
   output logic                busy,
   output logic                zero,
   output logic                done
);

   localparam int W = 4 * DIGITS;
   localparam logic [W-1:0] c_one = {{(W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t         r_state;
   state_t         w_state_nx;
   logic [W-1:0]   r_q;
   logic [W-1:0]   w_q_nx;
   logic [W-1:0]   w_q_dec;
   logic [W-1:0]   w_q_load;
   logic           r_done;
   logic           w_done_nx;
   logic [DIGITS-1:0] w_borrow;

   assign w_borrow[0] = 1'b1;

   // Per-digit clamp of the preset and a ripple-borrow decrement chain.
   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign w_q_load[4*gi +: 4] = (load_val[4*gi +: 4] > 4'd9) ? 4'd9 : load_val[4*gi +: 4];
         assign w_q_dec[4*gi +: 4]  = !w_borrow[gi]          ? r_q[4*gi +: 4] :
                                      (r_q[4*gi +: 4] == 4'd0) ? 4'd9 :
                                                                 r_q[4*gi +: 4] - 4'd1;
         if (gi < DIGITS - 1) begin : g_chain
            assign w_borrow[gi+1] = w_borrow[gi] && (r_q[4*gi +: 4] == 4'd0);
         end
      end
   endgenerate

   always_comb begin
      w_state_nx = r_state;
      w_q_nx     = r_q;
      w_done_nx  = 1'b0;
      // Each request only claims the cycle in states where it acts.
      if (load && (r_state != S_RUN)) begin
         w_q_nx     = w_q_load;
         w_state_nx = S_IDLE;
      end else if (pause && ((r_state == S_RUN) || (r_state == S_PAUSE))) begin
         w_state_nx = S_PAUSE;
      end else if (start && ((r_state == S_IDLE) || (r_state == S_PAUSE))) begin
         if ((r_state == S_IDLE) && (r_q == '0)) begin
            w_state_nx = S_DONE;
            w_done_nx  = 1'b1;
         end else begin
            w_state_nx = S_RUN;
         end
      end else if (tick && (r_state == S_RUN)) begin
         w_q_nx = w_q_dec;
         if (r_q == c_one) begin
            w_state_nx = S_DONE;
            w_done_nx  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_q     <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_q     <= w_q_nx;
         r_done  <= w_done_nx;
      end
   end

   assign q    = r_q;
   assign done = r_done;
   assign busy = (r_state == S_RUN) || (r_state == S_PAUSE);
   assign zero = (r_q == '0) || reset;

endmodule
`default_nettype wire

// File: tb/tb_bcd_down_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bcd_down_timer                                            |
// | Description : Self-checking bench for bcd_down_timer (DIGITS=2).           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bcd_down_timer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tick = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_val = 8'h00;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic [7:0] q;
   logic       busy;
   logic       zero;
   logic       done;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0] eq;
      logic       eb;
      logic       ed;
   } exp_t;

   typedef struct {
      logic       tk;
      logic       ld;
      logic [7:0] lv;
      logic       st;
      logic       pa;
      logic [7:0] eq;
      logic       eb;
      logic       ed;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[16];

   bcd_down_timer #(.DIGITS(2)) dut (
      .clk(clk), .reset(reset), .tick(tick), .load(load), .load_val(load_val),
      .start(start), .pause(pause), .q(q), .busy(busy), .zero(zero), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] to_bcd(input int v);
      return {4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
      end
   endtask

   // One clock of stimulus: drive at negedge, push expectation, compare after posedge.
   task automatic step(input logic tk, input logic ld, input logic [7:0] lv,
                       input logic st, input logic pa,
                       input logic [7:0] eq, input logic eb, input logic ed);
      exp_t e;
      @(negedge clk);
      tick = tk; load = ld; load_val = lv; start = st; pause = pa;
      e.eq = eq; e.eb = eb; e.ed = ed;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("q", 32'(q), 32'(e.eq));
      chk("busy", 32'(busy), 32'(e.eb));
      chk("done", 32'(done), 32'(e.ed));
      chk("zero", 32'(zero), 32'(e.eq == 8'h00));
   endtask

   // Count from current value 'from' down to zero with one tick per cycle.
   task automatic count_to_zero(input int from);
      for (int v = from - 1; v >= 0; v--)
         step(1, 0, 8'h00, 0, 0, to_bcd(v), (v != 0), (v == 0));
      step(0, 0, 8'h00, 0, 0, 8'h00, 0, 0);
   endtask

   initial begin
      //           tk ld lv     st pa  q      busy done
      vecs[0]  = '{0, 1, 8'h3C, 0, 0, 8'h39, 0, 0};  // clamp low nibble
      vecs[1]  = '{1, 0, 8'h00, 0, 0, 8'h39, 0, 0};  // tick in IDLE ignored
      vecs[2]  = '{0, 0, 8'h00, 1, 0, 8'h39, 1, 0};
      vecs[3]  = '{1, 0, 8'h00, 0, 0, 8'h38, 1, 0};
      vecs[4]  = '{1, 0, 8'h00, 0, 1, 8'h38, 1, 0};  // pause beats tick
      vecs[5]  = '{1, 0, 8'h00, 0, 0, 8'h38, 1, 0};  // tick in PAUSE ignored
      vecs[6]  = '{1, 0, 8'h00, 1, 1, 8'h38, 1, 0};  // start+pause stays paused
      vecs[7]  = '{0, 0, 8'h00, 1, 0, 8'h38, 1, 0};  // resume
      vecs[8]  = '{1, 0, 8'h00, 0, 0, 8'h37, 1, 0};
      vecs[9]  = '{1, 1, 8'h50, 0, 0, 8'h36, 1, 0};  // load ignored in RUN
      vecs[10] = '{0, 0, 8'h00, 0, 1, 8'h36, 1, 0};
      vecs[11] = '{0, 1, 8'hAF, 0, 0, 8'h99, 0, 0};  // load in PAUSE, both clamp
      vecs[12] = '{0, 1, 8'h10, 0, 0, 8'h10, 0, 0};
      vecs[13] = '{0, 0, 8'h00, 1, 0, 8'h10, 1, 0};
      vecs[14] = '{1, 0, 8'h00, 0, 0, 8'h09, 1, 0};  // borrow 10 -> 09
      vecs[15] = '{0, 1, 8'h01, 1, 0, 8'h09, 1, 0};  // load/start ignored in RUN

      reset = 1'b1;
      #3;
      chk("rst_q", 32'(q), 32'h0);
      chk("rst_zero", 32'(zero), 32'h1);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 16; i++)
         step(vecs[i].tk, vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].pa,
              vecs[i].eq, vecs[i].eb, vecs[i].ed);
      count_to_zero(9);

      // 25 down through the 20 -> 19 borrow to a done pulse
      step(0, 1, 8'h25, 0, 0, 8'h25, 0, 0);
      step(0, 0, 8'h00, 1, 0, 8'h25, 1, 0);
      count_to_zero(25);
      step(1, 0, 8'h00, 1, 0, 8'h00, 0, 0);  // DONE ignores start and tick

      // Asynchronous reset in the middle of a count
      step(0, 1, 8'h3C, 0, 0, 8'h39, 0, 0);
      step(0, 0, 8'h00, 1, 0, 8'h39, 1, 0);
      for (int v = 38; v >= 29; v--)
         step(1, 0, 8'h00, 0, 0, to_bcd(v), 1, 0);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async_q", 32'(q), 32'h0);
      chk("async_zero", 32'(zero), 32'h1);
      chk("async_busy", 32'(busy), 32'h0);
      chk("async_done", 32'(done), 32'h0);
      @(posedge clk);
      #1;
      chk("async_hold_done", 32'(done), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      tick = 1'b0;

      // Pause mid-run, then resume to completion
      step(0, 1, 8'h12, 0, 0, 8'h12, 0, 0);
      step(0, 0, 8'h00, 1, 0, 8'h12, 1, 0);
      step(1, 0, 8'h00, 0, 0, 8'h11, 1, 0);
      step(1, 0, 8'h00, 0, 0, 8'h10, 1, 0);
      step(1, 0, 8'h00, 0, 1, 8'h10, 1, 0);
      step(0, 0, 8'h00, 1, 0, 8'h10, 1, 0);
      count_to_zero(10);

      // Start with zero count goes straight to DONE
      step(0, 1, 8'h00, 0, 0, 8'h00, 0, 0);
      step(0, 0, 8'h00, 1, 0, 8'h00, 0, 1);
      step(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);

      // Load at 05 while running is ignored; load from DONE is accepted
      step(0, 1, 8'h07, 0, 0, 8'h07, 0, 0);
      step(0, 0, 8'h00, 1, 0, 8'h07, 1, 0);
      step(1, 0, 8'h00, 0, 0, 8'h06, 1, 0);
      step(1, 0, 8'h00, 0, 0, 8'h05, 1, 0);
      step(1, 1, 8'h40, 0, 0, 8'h04, 1, 0);
      count_to_zero(4);
      step(0, 1, 8'h40, 0, 0, 8'h40, 0, 0);

      // Full-scale count
      step(0, 1, 8'h99, 0, 0, 8'h99, 0, 0);
      step(0, 0, 8'h00, 1, 0, 8'h99, 1, 0);
      count_to_zero(99);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
- Loadable multi-digit BCD down counter with a small control FSM.
- It is the countdown counterpart of the team's decade up-counter (0..9, carry at 9), running the other direction: each digit decrements 9..0 and borrows from the next digit.
- Used as a countdown timer behind a display driver. Decrements on an external enable pulse (tick), stops at zero and flags completion.

Parameters:
- DIGITS, 2, number of cascaded BCD digits (1..4); digit 0 is least significant, occupying q[3:0].

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- tick  input  1  count enable pulse, sampled at posedge clk.
- load  input  1  load request.
- load_val  input  4*DIGITS  BCD preset value.
- start  input  1  start/resume request.
- pause  input  1  pause request.
- q  output  4*DIGITS  current BCD count, registered.
- busy  output  1  high in RUN or PAUSE.
- zero  output  1  combinational; high when q is all zeros or reset is high.
- done  output  1  registered one-cycle pulse when countdown completes.

Behaviour:
- Reset (async, active-high):
  - q = 0, state = IDLE, done = 0, busy = 0, zero = 1.
  - Reset asserted mid-RUN aborts immediately; no done pulse.
- States: IDLE, RUN, PAUSE, DONE. busy = (state == RUN or state == PAUSE), derived from registered state.
- Per-cycle priority: reset > load > pause > start > tick.
- load:
  - Accepted in IDLE, PAUSE and DONE; ignored in RUN.
  - q <= load_val, with each nibble > 9 clamped to 9. State goes to IDLE.
- start:
  - In IDLE with q != 0: go to RUN.
  - In IDLE with q == 0: go to DONE, and done pulses 1 cycle.
  - In PAUSE: go to RUN.
  - Ignored in RUN and DONE.
- pause:
  - In RUN: go to PAUSE. No decrement that cycle, even if tick is high.
  - In PAUSE, start + pause together keeps PAUSE.
- RUN with tick high:
  - Digit 0 decrements. Any digit going 0 -> 9 generates a borrow into the next digit, which decrements.
  - If the count equals 1 before the edge, q becomes 0 on that edge, the state goes to DONE, and done = 1 for exactly that following cycle.
- RUN with tick low: q holds.
- done timing: latency from the final tick to done = 1 clock; done is 0 in all other cycles.
- DONE: q holds at 0; only load exits.
- Boundary cases:
  - Wrap-around below 0 is impossible (RUN never entered with q == 0).
  - Max load (all 9s) counts down 10^DIGITS - 1 ticks.
  - A tick outside RUN has no effect.

Test Plan (DIGITS=2):
- Assert reset mid-count -> q=00, zero=1, busy=0, done=0 immediately (asynchronous).
- Load 0x25, start, 25 ticks -> q=24, 23, 22, 21, 20, 19 (borrow 20 -> 19) ... 01, 00; done high exactly 1 cycle after the 25th tick; state DONE.
- Load 0x3C -> q=39 (clamp). Start, 10 ticks -> q=29.
- Load 0x12, start, 2 ticks -> q=10. Pause and tick in the same cycle -> q stays 10, busy=1. Start -> resume; 10 more ticks -> 00 with done pulse.
- Load 0x00, start -> done pulse next cycle; q=00; no RUN entry.
- In RUN at q=05, assert load=1 with load_val=0x40 -> ignored, q keeps counting. In DONE, load 0x40 -> q=40, state IDLE, zero=0.
